// File: rtl/line_window_buffer.sv
// F-row sliding line buffer: collects raster pixels into a ring of F+1 full-width
// row slots and presents F vertically adjacent rows, with optional zero row padding.
module line_window_buffer #(
    parameter int DATA_BITS = 8,
    parameter int D         = 1,
    parameter int H         = 24,
    parameter int W         = 24,
    parameter int F         = 3,
    parameter int PAD       = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [D*DATA_BITS-1:0]         data_i,
    output logic                           valid_o,
    output logic [F*W*D*DATA_BITS-1:0]     rows_o,
    output logic [$clog2(H+2)-1:0]         win_row_o,
    input  logic                           done_i,
    output logic                           frame_done_o
);
    localparam int P        = (PAD != 0) ? (F - 1) / 2 : 0;
    localparam int NR       = F + 1;
    localparam int PIX_BITS = D * DATA_BITS;
    localparam int ROW_BITS = W * PIX_BITS;
    localparam int SW       = $clog2(NR);
    localparam int AW       = $clog2(NR + 1);
    localparam int CW       = (W > 1) ? $clog2(W) : 1;
    localparam int RW       = $clog2(H + 1);
    localparam int WRW      = $clog2(H + 2);

    localparam logic [CW-1:0]  COL_LAST   = CW'(W - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(H - 1);
    localparam logic [AW-1:0]  AVAIL_FULL = AW'(NR);
    localparam logic [AW-1:0]  AVAIL_WIN  = AW'(F);
    localparam logic [AW-1:0]  AVAIL_INIT = AW'(P);
    localparam logic [AW-1:0]  PAD_LAST   = AW'((P > 0) ? P - 1 : 0);
    localparam logic [SW-1:0]  SLOT_INIT  = SW'(P);
    localparam logic [WRW-1:0] WIN_LAST   = WRW'(H + 2 * P - F);

    typedef enum logic [1:0] {FILL, FLUSH, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [NR-1:0][ROW_BITS-1:0] mem_q, mem_d;
    logic [SW-1:0]              head_q, head_d;
    logic [SW-1:0]              wr_q, wr_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              in_row_q, in_row_d;
    logic [AW-1:0]              avail_q, avail_d;
    logic [AW-1:0]              pad_q, pad_d;
    logic [WRW-1:0]             win_q, win_d;
    logic                       fdone_q, fdone_d;
    logic                       row_in;
    logic                       rel;

    function automatic logic [SW-1:0] slot_of(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NR) s = s - NR;
        return SW'(s);
    endfunction

    // Handshakes: an input beat moves when valid_i && ready_o at a rising edge; a window
    // is released when valid_o && done_i at a rising edge. ready_o/valid_o come from
    // registered state only, so neither valid_i nor done_i reaches any output combinationally.
    assign ready_o      = (state_q == FILL) && (avail_q < AVAIL_FULL);
    assign valid_o      = (avail_q >= AVAIL_WIN);
    assign win_row_o    = win_q;
    assign frame_done_o = fdone_q;

    always_comb begin
        rows_o = '0;
        for (int i = 0; i < F; i++) begin
            rows_o[i*ROW_BITS +: ROW_BITS] = mem_q[slot_of(head_q, i)];
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        head_d   = head_q;
        wr_d     = wr_q;
        col_d    = col_q;
        in_row_d = in_row_q;
        avail_d  = avail_q;
        pad_d    = pad_q;
        win_d    = win_q;
        fdone_d  = 1'b0;
        row_in   = 1'b0;
        rel      = valid_o && done_i;

        case (state_q)
            FILL: begin
                if (valid_i && ready_o) begin
                    mem_d[wr_q][col_q*PIX_BITS +: PIX_BITS] = data_i;
                    if (col_q == COL_LAST) begin
                        col_d    = '0;
                        in_row_d = in_row_q + 1'b1;
                        row_in   = 1'b1;
                        if (in_row_q == ROW_LAST) state_d = (P > 0) ? FLUSH : DRAIN;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (avail_q < AVAIL_FULL) begin
                    mem_d[wr_q] = '0;
                    row_in      = 1'b1;
                    pad_d       = pad_q + 1'b1;
                    if (pad_q == PAD_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: state_d = FILL;
        endcase

        if (row_in) wr_d = slot_of(wr_q, 1);
        if (rel) begin
            head_d = slot_of(head_q, 1);
            win_d  = win_q + 1'b1;
        end
        case ({row_in, rel})
            2'b10:   avail_d = avail_q + 1'b1;
            2'b01:   avail_d = avail_q - 1'b1;
            default: avail_d = avail_q;
        endcase

        // Releasing the last window rewinds to frame-start state; the top pad slots are zero.
        if (rel && (win_q == WIN_LAST)) begin
            fdone_d  = 1'b1;
            state_d  = FILL;
            mem_d    = '0;
            head_d   = '0;
            wr_d     = SLOT_INIT;
            col_d    = '0;
            in_row_d = '0;
            avail_d  = AVAIL_INIT;
            pad_d    = '0;
            win_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            mem_q    <= '0;
            head_q   <= '0;
            wr_q     <= SLOT_INIT;
            col_q    <= '0;
            in_row_q <= '0;
            avail_q  <= AVAIL_INIT;
            pad_q    <= '0;
            win_q    <= '0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_q     <= wr_d;
            col_q    <= col_d;
            in_row_q <= in_row_d;
            avail_q  <= avail_d;
            pad_q    <= pad_d;
            win_q    <= win_d;
            fdone_q  <= fdone_d;
        end
    end
endmodule
